// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory access sequencer and the datapath size handler.
// The op codes here are the size-handler select encoding, so both blocks decode them the same way.
package mem_seq_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_SB    = 3'b000;
  localparam op_t OP_SW    = 3'b001;
  localparam op_t OP_SH    = 3'b010;
  localparam op_t OP_LB    = 3'b011;
  localparam op_t OP_LW    = 3'b100;
  localparam op_t OP_LH    = 3'b101;
  localparam op_t SEL_IDLE = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } state_t;

  function automatic logic is_load(op_t op);
    return (op == OP_LB) || (op == OP_LW) || (op == OP_LH);
  endfunction

  // Alignment and op legality; the low address bits are the only ones that matter.
  function automatic logic access_ok(op_t op, logic [1:0] a);
    logic ok;
    case (op)
      OP_SW, OP_LW: ok = (a == 2'b00);
      OP_SH, OP_LH: ok = ~a[0];
      OP_SB, OP_LB: ok = 1'b1;
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Control-unit request / memory-side bundle of the memory access sequencer.
// master = control unit side, slave = sequencer side.
interface mem_access_sequencer_if;
  import mem_seq_pkg::*;

  logic        start;
  op_t         op;
  logic [31:0] addr_in;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] mem_addr;
  logic        mem_wr;
  op_t         sh_sel;
  logic        mdr_we;

  modport master (
    output start, op, addr_in,
    input  busy, done, fault, mem_addr, mem_wr, sh_sel, mdr_we
  );

  modport slave (
    input  start, op, addr_in,
    output busy, done, fault, mem_addr, mem_wr, sh_sel, mdr_we
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Multicycle load/store sequencer: drives memory address/write enable and the size-handler
// select; sub-word stores are done as read-modify-write.
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input logic                  clk,
  input logic                  reset,
  mem_access_sequencer_if.slave bus
);

  // state   | meaning
  // IDLE    | waiting for start; sh_sel inert
  // READ    | memory read in flight, counting MEM_LAT cycles
  // CAPTURE | load data valid at size handler; load MDR
  // WRITE   | write merged/full word to memory
  // DONE    | completion pulse
  // ERR     | refused access: done + fault, no memory side effects

  localparam logic [1:0] CNT_LOAD = 2'(MEM_LAT - 1);

  state_t      state_q, state_d;
  op_t         op_q;
  logic [31:0] addr_q;
  logic [1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_SB;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_IDLE && bus.start) begin
        op_q   <= bus.op;
        addr_q <= bus.addr_in;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    bus.fault    = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.mdr_we   = 1'b0;
    bus.sh_sel   = op_q;
    bus.mem_addr = addr_q;

    case (state_q)
      ST_IDLE: begin
        bus.busy   = 1'b0;
        bus.sh_sel = SEL_IDLE;
        if (bus.start) begin
          if (!access_ok(bus.op, bus.addr_in[1:0])) begin
            state_d = ST_ERR;
          end else if (bus.op == OP_SW) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_READ: begin
        if (cnt_q == 2'd0) begin
          state_d = is_load(op_q) ? ST_CAPTURE : ST_WRITE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_CAPTURE: begin
        bus.mdr_we = 1'b1;
        state_d    = ST_DONE;
      end
      ST_WRITE: begin
        bus.mem_wr = 1'b1;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        bus.done = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_ERR: begin
        bus.done  = 1'b1;
        bus.fault = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: two instances (MEM_LAT 1 and 3) checked every cycle
// against a per-request output schedule, plus directed latency/strobe expectations.
module tb_mem_access_sequencer;
  import mem_seq_pkg::*;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        fault;
    logic        wr;
    logic        mdr;
    logic [2:0]  sel;
    logic [31:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_access_sequencer_if bus1();
  mem_access_sequencer_if bus3();

  mem_access_sequencer #(.MEM_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  mem_access_sequencer #(.MEM_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

  int checks = 0;
  int errors = 0;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] last_addr0 = '0;
  logic [31:0] last_addr1 = '0;

  function automatic exp_t sample(input int d);
    exp_t s;
    if (d == 0) s = '{bus1.busy, bus1.done, bus1.fault, bus1.mem_wr, bus1.mdr_we, bus1.sh_sel, bus1.mem_addr};
    else        s = '{bus3.busy, bus3.done, bus3.fault, bus3.mem_wr, bus3.mdr_we, bus3.sh_sel, bus3.mem_addr};
    return s;
  endfunction

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Schedule of outputs, one entry per cycle, for a request accepted by instance d.
  task automatic plan(input int d, input logic [2:0] op, input logic [31:0] a);
    exp_t e;
    int   lat;
    bit   legal;
    lat   = (d == 0) ? 1 : 3;
    legal = (op <= 3'd5)
          && !((op == OP_LW || op == OP_SW) && a[1:0] != 2'b00)
          && !((op == OP_LH || op == OP_SH) && a[0]);
    e = '{busy: 1'b1, done: 1'b0, fault: 1'b0, wr: 1'b0, mdr: 1'b0, sel: op, addr: a};
    if (!legal) begin
      e.done = 1'b1; e.fault = 1'b1; push(d, e);
    end else if (op == OP_SW) begin
      e.wr = 1'b1; push(d, e);
      e.wr = 1'b0; e.done = 1'b1; push(d, e);
    end else begin
      repeat (lat) push(d, e);
      if (op == OP_LB || op == OP_LW || op == OP_LH) e.mdr = 1'b1;
      else                                           e.wr  = 1'b1;
      push(d, e);
      e.mdr = 1'b0; e.wr = 1'b0; e.done = 1'b1; push(d, e);
    end
  endtask

  // Model: a request is taken only if the model was idle in the cycle ending at this edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q0.delete(); q1.delete();
      last_addr0 = '0; last_addr1 = '0;
    end else begin
      if (q0.size() == 0) begin
        if (bus1.start) begin plan(0, bus1.op, bus1.addr_in); last_addr0 = bus1.addr_in; end
      end else begin
        void'(q0.pop_front());
      end
      if (q1.size() == 0) begin
        if (bus3.start) begin plan(1, bus3.op, bus3.addr_in); last_addr1 = bus3.addr_in; end
      end else begin
        void'(q1.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    exp_t ex, ac;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) ex = (q0.size() != 0) ? q0[0] : exp_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SEL_IDLE, last_addr0};
      else        ex = (q1.size() != 0) ? q1[0] : exp_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SEL_IDLE, last_addr1};
      ac = sample(d);
      checks++;
      if (ac !== ex) begin
        errors++;
        $display("FAIL cycle_outputs dut%0d t=%0t actual busy/done/fault/wr/mdr=%b%b%b%b%b sel=%b addr=%h required %b%b%b%b%b sel=%b addr=%h",
                 d, $time, ac.busy, ac.done, ac.fault, ac.wr, ac.mdr, ac.sel, ac.addr,
                 ex.busy, ex.done, ex.fault, ex.wr, ex.mdr, ex.sel, ex.addr);
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Call at a negedge; returns at the negedge of the first cycle after the sampling edge.
  task automatic req(input int d, input logic [2:0] op, input logic [31:0] a);
    if (d == 0) begin bus1.start = 1'b1; bus1.op = op; bus1.addr_in = a; end
    else        begin bus3.start = 1'b1; bus3.op = op; bus3.addr_in = a; end
    @(negedge clk);
    bus1.start = 1'b0;
    bus3.start = 1'b0;
  endtask

  task automatic run_to_done(input int d, output int lat, output int nwr, output int nmdr,
                             output int wr_cyc, output int mdr_cyc, output int wr_sel, output int flt);
    exp_t s;
    lat = -1; nwr = 0; nmdr = 0; wr_cyc = -1; mdr_cyc = -1; wr_sel = -1; flt = -1;
    for (int n = 1; n <= 20; n++) begin
      s = sample(d);
      if (s.wr)  begin nwr++;  wr_cyc = n; wr_sel = int'(s.sel); end
      if (s.mdr) begin nmdr++; mdr_cyc = n; end
      if (s.done) begin lat = n; flt = int'(s.fault); break; end
      @(negedge clk);
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout dut%0d actual=no done in 20 cycles required=done", d);
    end
  endtask

  int lat, nwr, nmdr, wr_cyc, mdr_cyc, wr_sel, flt;
  int wr_seen;

  initial begin
    bus1.start = 1'b0; bus1.op = OP_SB; bus1.addr_in = '0;
    bus3.start = 1'b0; bus3.op = OP_SB; bus3.addr_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", bus1.busy, 0);
    chk("reset_sel", bus3.sh_sel, 7);
    chk("reset_addr", bus1.mem_addr, 0);

    // lw aligned, MEM_LAT=1
    req(0, OP_LW, 32'h0000_0010);
    chk("lw_sel_c1", bus1.sh_sel, 4);
    run_to_done(0, lat, nwr, nmdr, wr_cyc, mdr_cyc, wr_sel, flt);
    chk("lw_latency", lat, 3);
    chk("lw_mdr_cycle", mdr_cyc, 2);
    chk("lw_no_write", nwr, 0);
    chk("lw_fault", flt, 0);
    @(negedge clk);

    // sb read-modify-write, MEM_LAT=1 and 3
    req(0, OP_SB, 32'h0000_0013);
    run_to_done(0, lat, nwr, nmdr, wr_cyc, mdr_cyc, wr_sel, flt);
    chk("sb1_latency", lat, 3);
    chk("sb1_write_count", nwr, 1);
    chk("sb1_write_cycle", wr_cyc, 2);
    chk("sb1_write_sel", wr_sel, 0);
    @(negedge clk);
    req(1, OP_SB, 32'h0000_0013);
    run_to_done(1, lat, nwr, nmdr, wr_cyc, mdr_cyc, wr_sel, flt);
    chk("sb3_latency", lat, 5);
    chk("sb3_write_cycle", wr_cyc, 4);
    @(negedge clk);

    // sw needs no read
    req(0, OP_SW, 32'h0000_0004);
    run_to_done(0, lat, nwr, nmdr, wr_cyc, mdr_cyc, wr_sel, flt);
    chk("sw_latency", lat, 2);
    chk("sw_write_cycle", wr_cyc, 1);
    chk("sw_write_sel", wr_sel, 1);
    @(negedge clk);

    // refused accesses
    req(0, OP_LW, 32'h0000_0002);
    run_to_done(0, lat, nwr, nmdr, wr_cyc, mdr_cyc, wr_sel, flt);
    chk("lw_mis_latency", lat, 1); chk("lw_mis_fault", flt, 1);
    @(negedge clk);
    req(0, OP_SH, 32'h0000_0001);
    run_to_done(0, lat, nwr, nmdr, wr_cyc, mdr_cyc, wr_sel, flt);
    chk("sh_mis_latency", lat, 1); chk("sh_mis_fault", flt, 1); chk("sh_mis_wr", nwr, 0);
    @(negedge clk);
    req(0, 3'b110, 32'h0000_0008);
    run_to_done(0, lat, nwr, nmdr, wr_cyc, mdr_cyc, wr_sel, flt);
    chk("op110_latency", lat, 1); chk("op110_fault", flt, 1); chk("op110_mdr", nmdr, 0);
    @(negedge clk);

    // lb with a stray strobe while busy, then sh back-to-back, MEM_LAT=3
    req(1, OP_LB, 32'h0000_0021);
    fork
      run_to_done(1, lat, nwr, nmdr, wr_cyc, mdr_cyc, wr_sel, flt);
      begin
        bus3.start = 1'b1; bus3.op = OP_LW; bus3.addr_in = 32'h0000_0100;
        @(negedge clk);
        bus3.start = 1'b0;
      end
    join
    chk("lb_latency", lat, 5);
    chk("lb_mdr_count", nmdr, 1);
    chk("lb_no_write", nwr, 0);
    chk("lb_addr_kept", bus3.mem_addr, 32'h21);
    @(negedge clk);
    req(1, OP_SH, 32'h0000_0022);
    chk("sh_accepted_busy", bus3.busy, 1);
    run_to_done(1, lat, nwr, nmdr, wr_cyc, mdr_cyc, wr_sel, flt);
    chk("sh_latency", lat, 5);
    chk("sh_write_sel", wr_sel, 2);
    @(negedge clk);

    // reset during the read phase of an sh: no write may escape
    req(1, OP_SH, 32'h0000_0040);
    @(negedge clk);
    wr_seen = 0;
    #2 reset = 1'b1;
    #1;
    chk("rst_async_busy", bus3.busy, 0);
    chk("rst_async_wr", bus3.mem_wr, 0);
    repeat (3) begin
      @(negedge clk);
      if (bus3.mem_wr) wr_seen++;
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus3.mem_wr) wr_seen++;
    end
    chk("rst_no_write", wr_seen, 0);
    chk("rst_busy", bus3.busy, 0);
    chk("rst_sel", bus3.sh_sel, 7);

    req(1, OP_LW, 32'h0000_0080);
    run_to_done(1, lat, nwr, nmdr, wr_cyc, mdr_cyc, wr_sel, flt);
    chk("post_rst_latency", lat, 5);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
